io_out_ctrl: RTL
================

# io_out_ctrl

Output-port controller between the CPU and the simulation/console sink. Edge-detects 64-bit I/O writes from two requesters: requester 0 is the CPU `io_write`/`io_data` port, requester 1 is the debug/trap channel. A round-robin arbiter grants them into a FIFO, which drains to a single valid/ready consumer. This decouples CPU execution from sink back-pressure while keeping one-value-per-write semantics.

## Interface
- `DATA_W`, 64, payload width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
---
- `clk`  in  1  single clock; all state on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `req0_write`  in  1  requester 0 write strobe (level; rising edge = one write)
- `req0_data`  in  DATA_W  requester 0 payload, sampled on the detected edge
- `req1_write`  in  1  requester 1 write strobe
- `req1_data`  in  DATA_W  requester 1 payload
- `out_valid`  out  1  FIFO head valid
- `out_data`  out  DATA_W  FIFO head payload
- `out_src`  out  1  FIFO head source (0/1)
- `out_ready`  in  1  consumer accepts head
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy
- `drop_count`  out  32  dropped writes (only with `IO_OUT_DROP_CNT_EN`)

## Operation
- Edge detect, per requester: `prev_i` registered. An event occurs when `req_i_write & ~prev_i`. A level held high is one event.
- Pending slot, per requester, one deep:
  - An event loads `{data}` and sets `pend_i`.
  - An event while `pend_i` is already set is dropped; the slot keeps the old data; drop counter +1.
  - If the pending entry is granted in that same cycle, the new event loads the slot instead and is not dropped.
- Arbiter, one grant per cycle:
  - Candidates are requesters with `pend_i`.
  - Grant occurs only if the FIFO can push: `count < DEPTH`, or a pop happens in the same cycle.
  - If both candidates are pending, the requester named by `rr` wins. After any grant, `rr` points to the other requester.
  - If only one is pending, it wins and `rr` is still updated.
- Push: the granted slot's data plus its source index enter the FIFO; `pend_i` clears.
- FIFO is first-word-fall-through.
  - `out_valid = count != 0`.
  - Pop on `out_valid & out_ready`.
  - Push and pop together leave the count unchanged, including at full and at count 1. At empty, push only.
- Full FIFO: pending slots hold (back-pressure); further edges on a held requester drop.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. The count is separate.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `fifo_count=0`, `drop_count=0`. Also `prev_i=0`, `pend_i=0`, `rr=0`, pointers 0.
- Reset mid-operation flushes FIFO and pending slots immediately (async); queued data is lost.
- Latency:
  - Edge sampled at posedge k sets `pend` at k.
  - Grant and push at k+1.
  - `out_valid`/`out_data` visible after k+1.
  - Consumed at the first posedge with `out_ready=1` thereafter.
- Throughput: one push and one pop per cycle. Two simultaneous events occupy two consecutive push cycles.
- `out_data`/`out_src` remain stable while `out_valid & ~out_ready`.

## Configuration
- `IO_OUT_DROP_CNT_EN` defined:
  - 32-bit saturating `drop_count` port and register.
  - Increments by the number of dropped events per cycle (0–2).
  - Saturates at 0xFFFF_FFFF.
- Not defined: the port is absent and drops are silent; all other behaviour is identical.

## Structure
- Package `io_out_pkg`:
  - `IO_DATA_W=64`
  - `io_src_t` (SRC_CPU=0, SRC_DBG=1)
  - `io_entry_t` struct `{src, data}`
- Sub-module `io_out_fifo`: parameterised FWFT FIFO of `io_entry_t`, with push/pop/count. The arbiter, edge detect and pending logic stay in the top.

## Test plan
- Reset, then single req0 edge with data 42 at posedge k → `out_valid` after k+1, `out_data=42`, `out_src=0`; pop with ready → count 0.
- Both requesters edge in the same cycle (data 7, 9), ready=1 → outputs 7 (src 0) then 9 (src 1) on consecutive cycles. A repeat of the same stimulus yields 9 before 7 only if `rr` points to 1; check the `rr` alternation.
- `out_ready=0`, 8 req0 edges spaced 2 cycles apart → `fifo_count=8`. A ninth edge pends; a tenth edge drops, `drop_count=1` (macro on). Then ready=1 → values drain in order, and the pended ninth value enters on the first pop cycle.
- FIFO full with ready=1 and pend set → push and pop in the same cycle; count stays at 8; no drop.
- req0_write held high for 20 cycles → exactly one entry.
- Assert `rst` with 3 entries queued → immediately `out_valid=0`, `fifo_count=0`; after release, a new edge of 5 → `out_data=5`.

Source files
------------

// File: rtl/io_out_pkg.sv
// io_out_pkg: shared types and widths for the I/O output controller
package io_out_pkg;

    localparam int IO_DATA_W = 64;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DBG = 1'b1
    } io_src_t;

    typedef struct packed {
        io_src_t                src;
        logic [IO_DATA_W-1:0]   data;
    } io_entry_t;

endpackage

// File: rtl/io_out_ctrl_if.sv
// io_out_ctrl_if: requester strobes and consumer handshake of the output controller (drop_count under IO_OUT_DROP_CNT_EN)
interface io_out_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
);
    logic                       req0_write;
    logic [DATA_W-1:0]          req0_data;
    logic                       req1_write;
    logic [DATA_W-1:0]          req1_data;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_src;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     fifo_count;
`ifdef IO_OUT_DROP_CNT_EN
    logic [31:0]                drop_count;

    modport master (
        output req0_write, req0_data, req1_write, req1_data, out_ready,
        input  out_valid, out_data, out_src, fifo_count, drop_count
    );
    modport slave (
        input  req0_write, req0_data, req1_write, req1_data, out_ready,
        output out_valid, out_data, out_src, fifo_count, drop_count
    );
`else
    modport master (
        output req0_write, req0_data, req1_write, req1_data, out_ready,
        input  out_valid, out_data, out_src, fifo_count
    );
    modport slave (
        input  req0_write, req0_data, req1_write, req1_data, out_ready,
        output out_valid, out_data, out_src, fifo_count
    );
`endif
endinterface

// File: rtl/io_out_fifo.sv
// io_out_fifo: first-word-fall-through FIFO of io_entry_t with separate occupancy count
module io_out_fifo
    import io_out_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  io_entry_t       push_data_i,
    input  logic            pop_i,
    output io_entry_t       head_o,
    output logic            valid_o,
    output logic [CW-1:0]   count_o
);
    io_entry_t          mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_pop;

    // next-state for pointers and count; pop is ignored when empty
    always_comb begin
        do_pop   = pop_i & valid_o;
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(do_pop);
    end

    // pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = count_q != '0;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/io_out_ctrl.sv
// io_out_ctrl: edge-detected two-requester round-robin output queue; IO_OUT_DROP_CNT_EN adds a saturating drop counter
module io_out_ctrl
    import io_out_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    io_out_ctrl_if.slave    io_if
);
    logic [1:0]         prev_q, pend_q, pend_d, ev, gnt, load;
    logic [DATA_W-1:0]  slot_q [2];
    logic [DATA_W-1:0]  slot_d [2];
    logic               rr_q, rr_d, pop, can_push, push, valid;
    io_entry_t          push_e, head;
    logic [CW-1:0]      count;

    // edge detect, round-robin grant and pending-slot update
    always_comb begin
        ev          = {io_if.req1_write, io_if.req0_write} & ~prev_q;
        pop         = valid & io_if.out_ready;
        can_push    = (count != CW'(DEPTH)) | pop;
        gnt[0]      = can_push & pend_q[0] & (~pend_q[1] | ~rr_q);
        gnt[1]      = can_push & pend_q[1] & (~pend_q[0] | rr_q);
        push        = |gnt;
        push_e.src  = gnt[1] ? SRC_DBG : SRC_CPU;
        push_e.data = gnt[1] ? slot_q[1] : slot_q[0];
        load        = ev & (~pend_q | gnt);
        pend_d      = ev | (pend_q & ~gnt);
        slot_d[0]   = load[0] ? io_if.req0_data : slot_q[0];
        slot_d[1]   = load[1] ? io_if.req1_data : slot_q[1];
        rr_d        = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : rr_q;
    end

    // requester-side state: previous strobe, pending flags, slot data, round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pend_q    <= '0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rr_q      <= 1'b0;
        end else begin
            prev_q    <= {io_if.req1_write, io_if.req0_write};
            pend_q    <= pend_d;
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            rr_q      <= rr_d;
        end
    end

    io_out_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_e),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (valid),
        .count_o     (count)
    );

    assign io_if.out_valid  = valid;
    assign io_if.out_data   = head.data;
    assign io_if.out_src    = head.src;
    assign io_if.fifo_count = count;

`ifdef IO_OUT_DROP_CNT_EN
    logic [1:0]     drop;
    logic [32:0]    drop_sum;
    logic [31:0]    drop_q, drop_d;

    // an event dropped when its slot is still occupied and not being granted
    always_comb begin
        drop     = ev & pend_q & ~gnt;
        drop_sum = {1'b0, drop_q} + 33'(drop[0]) + 33'(drop[1]);
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    // saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign io_if.drop_count = drop_q;
`endif

endmodule
